// File: rtl/hzd_pkg.sv
// -----------------------------------------------------------------------------
// hzd_pkg
// Shared definitions for the pipeline hazard controller.
//   hzd_state_e     : controller FSM state (RUN / LD_STALL / MDU_WAIT).
//   LD_STALL_CYC_MIN: smallest legal load-use stall length.
//   LD_STALL_CYC_MAX: largest legal load-use stall length.
//   LD_CNT_W        : width of the stall down-counter (holds up to MAX-1).
//   clamp_ld_cyc()  : forces a stall length into the legal range.
// -----------------------------------------------------------------------------
package hzd_pkg;

  typedef enum logic [1:0] {
    HZD_RUN      = 2'd0,
    HZD_LD_STALL = 2'd1,
    HZD_MDU_WAIT = 2'd2
  } hzd_state_e;

  localparam int LD_STALL_CYC_MIN = 1;
  localparam int LD_STALL_CYC_MAX = 4;
  localparam int LD_CNT_W         = 2;

  function automatic int clamp_ld_cyc(input int cyc);
    if (cyc < LD_STALL_CYC_MIN) return LD_STALL_CYC_MIN;
    if (cyc > LD_STALL_CYC_MAX) return LD_STALL_CYC_MAX;
    return cyc;
  endfunction

endpackage

// File: rtl/hzd_match.sv
// -----------------------------------------------------------------------------
// hzd_match
// Load-use comparator: flags when the instruction in ID reads a register that
// the load currently in EX is about to write. Register 0 is never a hazard.
// Ports:
//   ifid_rs1/rs2_i      : ID-stage source register addresses
//   ifid_use_rs1/rs2_i  : source operand actually read
//   idex_mem_read_i     : EX-stage instruction is a load
//   idex_rd_i           : EX-stage destination register
//   hit_o               : load-use hazard present
// -----------------------------------------------------------------------------
module hzd_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              ifid_use_rs1_i,
  input  logic              ifid_use_rs2_i,
  input  logic              idex_mem_read_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  output logic              hit_o
);

  logic rd_nz;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nz   = (idex_rd_i != '0);
  assign rs1_hit = ifid_use_rs1_i && (ifid_rs1_i == idex_rd_i);
  assign rs2_hit = ifid_use_rs2_i && (ifid_rs2_i == idex_rd_i);
  assign hit_o   = idex_mem_read_i && rd_nz && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard controller: stalls for load-use hazards and busy multicycle
// mul/div, flushes on EX-resolved taken branches.
// Optional feature macro: HZD_PERF_CNT_EN adds saturating per-event counters.
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   ifid_rs1/rs2            : ID-stage source registers
//   ifid_use_rs1/rs2        : source actually read
//   idex_mem_read, idex_rd  : EX-stage load flag / destination
//   mdu_busy                : multicycle mul/div occupying EX
//   ex_branch_taken         : EX-resolved redirect
//   pc_write, ifid_write,
//   idex_write              : stage write enables
//   ifid_flush, idex_bubble : squash IF/ID, insert NOP into ID/EX
//   hzd_state               : current FSM state (debug visibility)
//   ld_stall_cnt, mdu_stall_cnt, flush_cnt : perf counters (HZD_PERF_CNT_EN)
// Handshake: none; all outputs are combinational functions of the registered
// state and the current-cycle inputs, valid for the whole cycle.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
  import hzd_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LD_STALL_CYC = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              mdu_busy,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        hzd_state
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  ld_stall_cnt,
  output logic [CNT_W-1:0]  mdu_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Remaining stall cycles after the one in which the hazard is detected.
  localparam logic [LD_CNT_W-1:0] LD_LOAD =
    LD_CNT_W'(clamp_ld_cyc(LD_STALL_CYC) - 1);

  logic [1:0]          state_q, state_d;
  logic [LD_CNT_W-1:0] cnt_q, cnt_d;
  logic                ld_hit;

  hzd_match #(.REG_AW(REG_AW)) u_match (
    .ifid_rs1_i      (ifid_rs1),
    .ifid_rs2_i      (ifid_rs2),
    .ifid_use_rs1_i  (ifid_use_rs1),
    .ifid_use_rs2_i  (ifid_use_rs2),
    .idex_mem_read_i (idex_mem_read),
    .idex_rd_i       (idex_rd),
    .hit_o           (ld_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZD_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = HZD_RUN;
    cnt_d   = '0;
    case (state_q)
      HZD_RUN: begin
        if (ex_branch_taken) begin
          state_d = HZD_RUN;
        end else if (mdu_busy) begin
          state_d = HZD_MDU_WAIT;
        end else if (ld_hit) begin
          cnt_d   = LD_LOAD;
          state_d = (LD_LOAD != '0) ? HZD_LD_STALL : HZD_RUN;
        end
      end
      HZD_LD_STALL: begin
        // Counter reaches the end on the edge where it reads 1; a zero value
        // here is unreachable but also exits rather than wrapping.
        if (cnt_q > LD_CNT_W'(1)) begin
          cnt_d   = cnt_q - LD_CNT_W'(1);
          state_d = HZD_LD_STALL;
        end
      end
      HZD_MDU_WAIT: begin
        state_d = mdu_busy ? HZD_MDU_WAIT : HZD_RUN;
      end
      default: begin
        state_d = HZD_RUN;
      end
    endcase
  end

  // Output logic; held at RUN defaults while reset is asserted so a stall
  // is released in the same instant rst_n falls.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst_n) begin
      case (state_q)
        HZD_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (mdu_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
          end else if (ld_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        HZD_LD_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        HZD_MDU_WAIT: begin
          if (mdu_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hzd_state = state_q;

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] ld_cnt_q, mdu_cnt_q, fl_cnt_q;
  logic             ld_ev, mdu_ev, fl_ev;

  // Events are decoded from the outputs: a load stall is the only case with
  // a bubble but no flush; an MDU stall is the only case blocking ID/EX.
  assign ld_ev  = idex_bubble && !ifid_flush;
  assign mdu_ev = !idex_write;
  assign fl_ev  = ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      mdu_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (ld_ev  && (ld_cnt_q  != '1)) ld_cnt_q  <= ld_cnt_q  + CNT_W'(1);
      if (mdu_ev && (mdu_cnt_q != '1)) mdu_cnt_q <= mdu_cnt_q + CNT_W'(1);
      if (fl_ev  && (fl_cnt_q  != '1)) fl_cnt_q  <= fl_cnt_q  + CNT_W'(1);
    end
  end

  assign ld_stall_cnt  = ld_cnt_q;
  assign mdu_stall_cnt = mdu_cnt_q;
  assign flush_cnt     = fl_cnt_q;
`endif

endmodule
